// File: rtl/fetch_prefetch_queue.sv
// rtl/fetch_prefetch_queue.sv - fetch PC plus DEPTH-entry prefetch FIFO feeding decode
module fetch_prefetch_queue #(
  parameter int              XLEN     = 8,
  parameter int              ILEN     = 32,
  parameter int              DEPTH    = 4,
  parameter int              PC_STEP  = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  output logic                     imem_req,
  output logic [XLEN-1:0]          imem_addr,
  input  logic                     imem_rvalid,
  input  logic [ILEN-1:0]          imem_rdata,
  input  logic                     redirect,
  input  logic [XLEN-1:0]          redirect_pc,
  output logic                     instr_valid,
  input  logic                     instr_ready,
  output logic [ILEN-1:0]          instr_out,
  output logic [XLEN-1:0]          pc_out,
  output logic [XLEN-1:0]          pc_plus4_out,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [XLEN-1:0] fetch_pc;
  logic [ILEN-1:0] instr_mem [DEPTH];
  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [AW-1:0]   wptr;
  logic [AW-1:0]   rptr;
  logic [LW-1:0]   count;
  logic            full;
  logic            pop;
  logic            push;

  assign full        = (count == LW'(DEPTH));
  assign instr_valid = (count != '0);
  assign pop         = en & instr_valid & instr_ready;
  // A pop frees the slot this cycle, so a full queue can still accept a fetch.
  assign imem_req    = en & ~redirect & (~full | pop);
  assign push        = imem_req & imem_rvalid;
  assign imem_addr   = fetch_pc;
  assign level       = count;

  assign instr_out    = instr_mem[rptr];
  assign pc_out       = pc_mem[rptr];
  assign pc_plus4_out = pc_out + XLEN'(PC_STEP);

  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc <= RESET_PC;
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      // Storage is cleared so the head reads 0 / RESET_PC straight out of reset.
      for (int i = 0; i < DEPTH; i++) begin
        instr_mem[i] <= '0;
        pc_mem[i]    <= RESET_PC;
      end
    end else if (en) begin
      if (redirect) begin
        fetch_pc <= redirect_pc;
        wptr     <= '0;
        rptr     <= '0;
        count    <= '0;
      end else begin
        if (push) begin
          instr_mem[wptr] <= imem_rdata;
          pc_mem[wptr]    <= fetch_pc;
          wptr            <= wptr + 1'b1;
          fetch_pc        <= fetch_pc + XLEN'(PC_STEP);
        end
        if (pop) begin
          rptr <= rptr + 1'b1;
        end
        count <= count + LW'(push) - LW'(pop);
      end
    end
  end

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// tb/tb_fetch_prefetch_queue.sv - directed self-checking bench for fetch_prefetch_queue
module tb_fetch_prefetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [7:0]  redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_out;
  logic [7:0]  pc_out;
  logic [7:0]  pc_plus4_out;
  logic [2:0]  level;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [7:0] a);
    return {16'hC0DE, 8'h00, a};
  endfunction

  // Combinational instruction ROM
  always_comb imem_rdata = rom(imem_addr);

  fetch_prefetch_queue dut (
    .clk(clk), .rst(rst), .en(en),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_out(instr_out), .pc_out(pc_out), .pc_plus4_out(pc_plus4_out),
    .level(level)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; en = 1'b1; redirect = 1'b0; redirect_pc = 8'h00;
    imem_rvalid = 1'b0; instr_ready = 1'b0;
    tick(); tick();
    rst = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (level !== 3'd0) begin fails++; $display("FAIL reset_level got %0d exp 0", level); end
    tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", instr_valid); end
    tests++; if (instr_out !== 32'h0) begin fails++; $display("FAIL reset_instr got %h exp 0", instr_out); end
    tests++; if (pc_out !== 8'h00) begin fails++; $display("FAIL reset_pc_out got %h exp 00", pc_out); end
    tests++; if (imem_addr !== 8'h00) begin fails++; $display("FAIL reset_addr got %h exp 00", imem_addr); end
  endtask

  task automatic test_streaming();
    logic [7:0] exp_pc;
    instr_ready = 1'b1; imem_rvalid = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      exp_pc = 8'(4 * k);
      tests++; if (pc_out !== exp_pc) begin fails++; $display("FAIL stream_pc[%0d] got %h exp %h", k, pc_out, exp_pc); end
      tests++; if (pc_plus4_out !== exp_pc + 8'd4) begin fails++; $display("FAIL stream_pc4[%0d] got %h exp %h", k, pc_plus4_out, exp_pc + 8'd4); end
      tests++; if (instr_out !== rom(exp_pc)) begin fails++; $display("FAIL stream_instr[%0d] got %h exp %h", k, instr_out, rom(exp_pc)); end
      tests++; if (level !== 3'd1 || instr_valid !== 1'b1) begin fails++; $display("FAIL stream_level[%0d] got %0d/%b exp 1/1", k, level, instr_valid); end
      tick();
    end
  endtask

  task automatic test_fill();
    do_reset();
    imem_rvalid = 1'b1; instr_ready = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      tests++; if (imem_addr !== 8'(4 * i) || imem_req !== 1'b1) begin fails++; $display("FAIL fill_addr[%0d] got %h/%b exp %h/1", i, imem_addr, imem_req, 8'(4 * i)); end
      tick();
      tests++; if (level !== 3'(i + 1) || instr_valid !== 1'b1 || pc_out !== 8'h00) begin fails++; $display("FAIL fill_level[%0d] got %0d/%b/%h exp %0d/1/00", i, level, instr_valid, pc_out, i + 1); end
    end
    tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL fill_full_req got %b exp 0", imem_req); end
  endtask

  task automatic test_full_pop();
    instr_ready = 1'b1;
    #1;
    tests++; if (imem_req !== 1'b1 || level !== 3'd4) begin fails++; $display("FAIL fullpop_req got %b/%0d exp 1/4", imem_req, level); end
    tick();
    instr_ready = 1'b0;
    #1;
    tests++; if (level !== 3'd4) begin fails++; $display("FAIL fullpop_level got %0d exp 4", level); end
    tests++; if (pc_out !== 8'h04 || instr_out !== rom(8'h04)) begin fails++; $display("FAIL fullpop_head got %h/%h exp 04/%h", pc_out, instr_out, rom(8'h04)); end
    tests++; if (imem_addr !== 8'h14 || imem_req !== 1'b0) begin fails++; $display("FAIL fullpop_addr got %h/%b exp 14/0", imem_addr, imem_req); end
  endtask

  task automatic test_redirect();
    instr_ready = 1'b1; imem_rvalid = 1'b0;
    tick();
    redirect = 1'b1; redirect_pc = 8'h40; instr_ready = 1'b1; imem_rvalid = 1'b1;
    #1;
    tests++; if (level !== 3'd3 || imem_req !== 1'b0) begin fails++; $display("FAIL redir_pre got %0d/%b exp 3/0", level, imem_req); end
    tick();
    redirect = 1'b0; instr_ready = 1'b0;
    #1;
    tests++; if (instr_valid !== 1'b0 || level !== 3'd0) begin fails++; $display("FAIL redir_flush got %b/%0d exp 0/0", instr_valid, level); end
    tests++; if (imem_addr !== 8'h40 || imem_req !== 1'b1) begin fails++; $display("FAIL redir_addr got %h/%b exp 40/1", imem_addr, imem_req); end
    tick();
    tests++; if (instr_valid !== 1'b1 || pc_out !== 8'h40 || instr_out !== rom(8'h40)) begin fails++; $display("FAIL redir_head got %b/%h/%h exp 1/40/%h", instr_valid, pc_out, instr_out, rom(8'h40)); end
  endtask

  task automatic test_back_to_back();
    redirect = 1'b1; redirect_pc = 8'h80;
    tick();
    redirect_pc = 8'h90;
    tick();
    redirect = 1'b0;
    #1;
    tests++; if (imem_addr !== 8'h90 || level !== 3'd0) begin fails++; $display("FAIL b2b_addr got %h/%0d exp 90/0", imem_addr, level); end
    tick();
    tests++; if (pc_out !== 8'h90 || level !== 3'd1) begin fails++; $display("FAIL b2b_head got %h/%0d exp 90/1", pc_out, level); end
  endtask

  task automatic test_wait_wrap();
    logic [4:0] pattern;
    logic [7:0] exp_addr [5];
    logic [7:0] exp_pc [3];
    logic [7:0] exp_pc4 [3];
    pattern = 5'b11001;
    exp_addr = '{8'hF8, 8'hFC, 8'hFC, 8'hFC, 8'h00};
    exp_pc   = '{8'hF8, 8'hFC, 8'h00};
    exp_pc4  = '{8'hFC, 8'h00, 8'h04};
    redirect = 1'b1; redirect_pc = 8'hF8; imem_rvalid = 1'b1;
    tick();
    redirect = 1'b0;
    for (int i = 0; i < 5; i++) begin
      imem_rvalid = pattern[i];
      #1;
      tests++; if (imem_addr !== exp_addr[i]) begin fails++; $display("FAIL wait_addr[%0d] got %h exp %h", i, imem_addr, exp_addr[i]); end
      tick();
    end
    imem_rvalid = 1'b0;
    tests++; if (level !== 3'd3) begin fails++; $display("FAIL wait_level got %0d exp 3", level); end
    instr_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++; if (pc_out !== exp_pc[i] || pc_plus4_out !== exp_pc4[i]) begin fails++; $display("FAIL wrap_pc[%0d] got %h/%h exp %h/%h", i, pc_out, pc_plus4_out, exp_pc[i], exp_pc4[i]); end
      tick();
    end
    instr_ready = 1'b0;
    tests++; if (level !== 3'd0 || instr_valid !== 1'b0) begin fails++; $display("FAIL wrap_drain got %0d/%b exp 0/0", level, instr_valid); end
  endtask

  task automatic test_enable();
    imem_rvalid = 1'b1;
    tick();
    en = 1'b0; instr_ready = 1'b1;
    #1;
    tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL en_req got %b exp 0", imem_req); end
    tick(); tick();
    tests++; if (level !== 3'd1 || pc_out !== 8'h04 || imem_addr !== 8'h08) begin fails++; $display("FAIL en_hold got %0d/%h/%h exp 1/04/08", level, pc_out, imem_addr); end
    en = 1'b1; instr_ready = 1'b0;
  endtask

  task automatic test_mid_reset();
    imem_rvalid = 1'b1;
    tick();
    imem_rvalid = 1'b0;
    tests++; if (level !== 3'd2) begin fails++; $display("FAIL midrst_pre got %0d exp 2", level); end
    rst = 1'b0; redirect = 1'b1; redirect_pc = 8'h60;
    tick();
    rst = 1'b1; redirect = 1'b0;
    #1;
    tests++; if (level !== 3'd0 || instr_valid !== 1'b0) begin fails++; $display("FAIL midrst_level got %0d/%b exp 0/0", level, instr_valid); end
    tests++; if (imem_addr !== 8'h00 || pc_out !== 8'h00 || instr_out !== 32'h0) begin fails++; $display("FAIL midrst_pc got %h/%h/%h exp 00/00/0", imem_addr, pc_out, instr_out); end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_fill();
    test_full_pop();
    test_redirect();
    test_back_to_back();
    test_wait_wrap();
    test_enable();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
